// File: rtl/crypto1_key_check_if.sv
// Candidate and key handshake bundle for the Crypto1 verify stage.
// The master side supplies candidates and acknowledges keys; the slave side is the checker.
interface crypto1_key_check_if;
  logic        CAND_VALID;
  logic        CAND_READY;
  logic [23:0] CAND_EVEN;
  logic [23:0] CAND_ODD;
  logic        KEY_VALID;
  logic        KEY_ACK;
  logic [47:0] KEY;

  modport master (
    output CAND_VALID, CAND_EVEN, CAND_ODD, KEY_ACK,
    input  CAND_READY, KEY_VALID, KEY
  );

  modport slave (
    input  CAND_VALID, CAND_EVEN, CAND_ODD, KEY_ACK,
    output CAND_READY, KEY_VALID, KEY
  );
endinterface

// File: rtl/crypto1_key_check.sv
// Crypto1 candidate verifier: clocks one (even, odd) LFSR state at a time through the
// filter and compares the keystream bit-serially against BITSTREAM, aborting on the
// first mismatch and reporting a full NBITS match as KEY.
module crypto1_key_check #(
  parameter int NBITS = 48,
  parameter int CNT_W = 32
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [47:0]        BITSTREAM,
  crypto1_key_check_if.slave bus,
  output logic               FOUND,
  output logic               BUSY,
  output logic [CNT_W-1:0]   CHECKED
);

  localparam int STEP_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NBITS - 1);

  // LFSR feedback taps, split into the odd and even halves.
  localparam logic [23:0] ODD_TAPS  = 24'h29CE5C;
  localparam logic [23:0] EVEN_TAPS = 24'h870804;

  // Filter lookup tables: each 4-bit odd nibble selects one bit of f.
  localparam logic [19:0] F4_TBL = 20'hf22c0;
  localparam logic [19:0] F3_TBL = 20'h6c9c0;
  localparam logic [19:0] F2_TBL = 20'h3c8b0;
  localparam logic [19:0] F1_TBL = 20'h1e458;
  localparam logic [19:0] F0_TBL = 20'h0d938;
  localparam logic [31:0] KS_TBL = 32'hEC57E80A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } state_e;

  state_e            state;
  state_e            state_next;
  logic [23:0]       even_q;
  logic [23:0]       odd_q;
  logic [47:0]       hold_q;      // initial state of the candidate in flight, KEY bit order
  logic [STEP_W-1:0] step_q;      // index of the keystream bit being compared
  logic [47:0]       cand_key;
  logic              ks;
  logic              fb;
  logic              mismatch;
  logic              last_step;

  // Keystream bit of the current state: two-level table lookup on the odd half.
  function automatic logic filter_bit(input logic [23:0] o);
    logic [4:0] f;
    f[4] = F4_TBL[5'(o[3:0])   + 5'd4];
    f[3] = F3_TBL[5'(o[7:4])   + 5'd3];
    f[2] = F2_TBL[5'(o[11:8])  + 5'd2];
    f[1] = F1_TBL[5'(o[15:12]) + 5'd1];
    f[0] = F0_TBL[5'(o[19:16])];
    return KS_TBL[f];
  endfunction

  assign ks        = filter_bit(odd_q);
  assign fb        = (^(odd_q & ODD_TAPS)) ^ (^(even_q & EVEN_TAPS));
  assign mismatch  = (ks != BITSTREAM[step_q]);
  assign last_step = (step_q == LAST_STEP);

  // Interleave the incoming halves into KEY order: even bits at 2i, odd bits at 2i+1.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default first, so no path can infer a latch.
    cand_key = '0;
    for (int i = 0; i < 24; i++) begin
      cand_key[2*i]   = bus.CAND_EVEN[i];
      cand_key[2*i+1] = bus.CAND_ODD[i];
    end
  end

  // State register; reset overrides any handshake seen on the same edge.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: accept in IDLE, abort or finish in RUN, wait for the ack in HIT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.CAND_VALID) state_next = RUN;
      RUN: begin
        if (mismatch)       state_next = IDLE;
        else if (last_step) state_next = HIT;
      end
      HIT:     if (bus.KEY_ACK) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded purely from the state.
  always_comb begin
    bus.CAND_READY = (state == IDLE);
    bus.KEY_VALID  = (state == HIT);
    BUSY           = (state != IDLE);
  end

  // Datapath: load, step the LFSR, count rejects, publish verified keys.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      even_q  <= '0;
      odd_q   <= '0;
      hold_q  <= '0;
      step_q  <= '0;
      bus.KEY <= '0;
      FOUND   <= 1'b0;
      CHECKED <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.CAND_VALID) begin
            even_q <= bus.CAND_EVEN;
            odd_q  <= bus.CAND_ODD;
            hold_q <= cand_key;
            step_q <= '0;
          end
        end
        RUN: begin
          if (mismatch) begin
            if (CHECKED != '1) CHECKED <= CHECKED + CNT_W'(1);
          end else if (last_step) begin
            bus.KEY <= hold_q;
            FOUND   <= 1'b1;
          end else begin
            even_q <= odd_q;
            odd_q  <= {even_q[22:0], fb};
            step_q <= step_q + STEP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crypto1_key_check.sv
// Scoreboard bench for crypto1_key_check: the driver pushes the reference model's verdict
// for every accepted candidate, and a monitor pops it whenever the DUT reports a key or a reject.
module tb_crypto1_key_check;

  localparam int NBITS = 48;
  localparam logic [23:0] ODD_TAPS  = 24'h29CE5C;
  localparam logic [23:0] EVEN_TAPS = 24'h870804;

  typedef struct {
    bit          hit;
    int          fail_step;
    logic [47:0] key;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] bitstream;
  logic        found;
  logic        busy;
  logic [31:0] checked;

  int   nchecks = 0;
  int   nerrors = 0;
  exp_t exp_q[$];

  bit auto_ack   = 1'b0;
  bit manual_ack = 1'b0;

  int run_cnt     = 0;
  int exp_checked = 0;
  int hits_seen   = 0;
  int events_seen = 0;
  bit prev_busy   = 1'b0;
  bit prev_kv     = 1'b0;

  logic [47:0] stream4;

  crypto1_key_check_if bus ();

  crypto1_key_check #(.NBITS(NBITS), .CNT_W(32)) dut (
    .CLK      (clk),
    .RESET    (rst),
    .BITSTREAM(bitstream),
    .bus      (bus),
    .FOUND    (found),
    .BUSY     (busy),
    .CHECKED  (checked)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name);
    nchecks++;
    nerrors++;
    $display("FAIL %s: got no event expected one within the cycle budget", name);
  endtask

  // Reference filter, written straight from the shift-and-mask formulation.
  function automatic bit model_filter(input logic [23:0] o);
    logic [31:0] f;
    f = ((32'h000f22c0 >> o[3:0])   & 32'd16) |
        ((32'h0006c9c0 >> o[7:4])   & 32'd8)  |
        ((32'h0003c8b0 >> o[11:8])  & 32'd4)  |
        ((32'h0001e458 >> o[15:12]) & 32'd2)  |
        ((32'h0000d938 >> o[19:16]) & 32'd1);
    return ((32'hEC57E80A >> f) & 32'd1) != 32'd0;
  endfunction

  // Reference keystream: the 48-bit LFSR as one shift register r[], odd half on
  // even positions, shifted up by one each step with the feedback entering r[0].
  function automatic logic [47:0] model_keystream(input logic [23:0] e, input logic [23:0] o);
    bit          r[48];
    logic [23:0] odd_now;
    bit          fb;
    logic [47:0] ks;
    for (int i = 0; i < 24; i++) begin
      r[2*i]   = o[i];
      r[2*i+1] = e[i];
    end
    for (int k = 0; k < 48; k++) begin
      for (int i = 0; i < 24; i++) odd_now[i] = r[2*i];
      ks[k] = model_filter(odd_now);
      fb = 1'b0;
      for (int i = 0; i < 24; i++) begin
        if (ODD_TAPS[i])  fb ^= r[2*i];
        if (EVEN_TAPS[i]) fb ^= r[2*i+1];
      end
      for (int j = 47; j > 0; j--) r[j] = r[j-1];
      r[0] = fb;
    end
    return ks;
  endfunction

  function automatic exp_t make_exp(input logic [23:0] e, input logic [23:0] o, input logic [47:0] bs);
    exp_t        x;
    logic [47:0] ks;
    ks = model_keystream(e, o);
    x.hit = 1'b1;
    x.fail_step = -1;
    for (int i = 0; i < 24; i++) begin
      x.key[2*i]   = e[i];
      x.key[2*i+1] = o[i];
    end
    for (int k = 0; k < NBITS; k++) begin
      if (x.hit && ks[k] != bs[k]) begin
        x.hit = 1'b0;
        x.fail_step = k;
      end
    end
    return x;
  endfunction

  // Acknowledge driver: random acks in stream mode, otherwise follows manual_ack.
  always @(negedge clk) begin
    if (auto_ack) bus.KEY_ACK = bus.KEY_VALID && ($urandom_range(0, 2) == 0);
    else          bus.KEY_ACK = manual_ack;
  end

  // Monitor: a rising KEY_VALID is a hit, BUSY falling without a key is a reject.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      run_cnt     = 0;
      exp_checked = 0;
      prev_busy   = 1'b0;
      prev_kv     = 1'b0;
    end else begin
      if (busy && !bus.KEY_VALID) run_cnt++;
      if (bus.KEY_VALID && !prev_kv) begin
        events_seen++;
        hits_seen++;
        if (exp_q.size() == 0) report_fail("hit_without_candidate");
        else begin
          e = exp_q.pop_front();
          check("hit_expected", 64'(1), 64'(e.hit));
          check("hit_latency", 64'(run_cnt), 64'(NBITS));
          check("hit_key", 64'(bus.KEY), 64'(e.key));
          check("hit_found", 64'(found), 64'(1));
        end
        run_cnt = 0;
      end else if (prev_busy && !busy && !prev_kv) begin
        events_seen++;
        exp_checked++;
        if (exp_q.size() == 0) report_fail("reject_without_candidate");
        else begin
          e = exp_q.pop_front();
          check("reject_expected", 64'(0), 64'(e.hit));
          check("reject_step", 64'(run_cnt - 1), 64'(e.fail_step));
          check("reject_checked", 64'(checked), 64'(exp_checked));
        end
        run_cnt = 0;
      end
      prev_busy = busy;
      prev_kv   = bus.KEY_VALID;
    end
  end

  // Present one candidate, wait for acceptance, and log the model's verdict.
  task automatic send(input logic [23:0] e, input logic [23:0] o);
    int w = 0;
    @(negedge clk);
    bus.CAND_EVEN  = e;
    bus.CAND_ODD   = o;
    bus.CAND_VALID = 1'b1;
    while (!bus.CAND_READY && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (!bus.CAND_READY) begin
      report_fail("accept_timeout");
      bus.CAND_VALID = 1'b0;
    end else begin
      exp_q.push_back(make_exp(e, o, bitstream));
      @(posedge clk);
      #1 bus.CAND_VALID = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while ((busy || bus.KEY_VALID || exp_q.size() != 0) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (busy || bus.KEY_VALID || exp_q.size() != 0) report_fail("idle_timeout");
  endtask

  task automatic wait_kv();
    int w = 0;
    while (!bus.KEY_VALID && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus.KEY_VALID) report_fail("key_valid_timeout");
  endtask

  task automatic ack_key();
    int w = 0;
    @(posedge clk);
    #1 manual_ack = 1'b1;
    while (bus.KEY_VALID && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (bus.KEY_VALID) report_fail("ack_timeout");
    manual_ack = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    int          ins;
    int          exp_hits;
    int          exp_rej;
    int          base_hits;
    int          base_events;
    logic [23:0] re;
    logic [23:0] ro;
    logic [47:0] ks;
    exp_t        x;

    rst            = 1'b1;
    bitstream      = '0;
    bus.CAND_VALID = 1'b0;
    bus.CAND_EVEN  = '0;
    bus.CAND_ODD   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("reset_key_valid", 64'(bus.KEY_VALID), 64'(0));
    check("reset_found", 64'(found), 64'(0));
    check("reset_checked", 64'(checked), 64'(0));
    check("reset_ready", 64'(bus.CAND_READY), 64'(1));
    check("reset_key", 64'(bus.KEY), 64'(0));

    // All-zero state against an all-zero stream: full match, KEY=0.
    bitstream = 48'h0;
    send(24'h0, 24'h0);
    wait_kv();
    check("zero_key", 64'(bus.KEY), 64'(0));
    check("zero_found", 64'(found), 64'(1));
    ack_key();

    // First bit disagrees: abort at step 0, READY back two edges after accept.
    bitstream = 48'h1;
    manual_ack = 1'b1;
    send(24'h0, 24'h0);
    @(negedge clk);
    check("first_bit_ready_low", 64'(bus.CAND_READY), 64'(0));
    @(negedge clk);
    check("first_bit_ready_high", 64'(bus.CAND_READY), 64'(1));
    check("first_bit_checked", 64'(checked), 64'(1));
    manual_ack = 1'b0;
    wait_idle();

    // Known candidate even=0, odd=all-ones against its own model keystream.
    stream4 = model_keystream(24'h0, 24'hFFFFFF);
    check("known_ks_first_bit", 64'(stream4[0]), 64'(1));
    bitstream = stream4;
    send(24'h0, 24'hFFFFFF);
    wait_kv();
    check("known_key", 64'(bus.KEY), 64'(48'hAAAA_AAAA_AAAA));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("known_hold_valid", 64'(bus.KEY_VALID), 64'(1));
    end
    ack_key();
    check("known_ready_after_ack", 64'(bus.CAND_READY), 64'(1));
    check("known_key_retained", 64'(bus.KEY), 64'(48'hAAAA_AAAA_AAAA));

    // Same candidate with the last compared bit flipped; stray acks must be ignored.
    bitstream = stream4 ^ 48'h8000_0000_0000;
    manual_ack = 1'b1;
    send(24'h0, 24'hFFFFFF);
    wait_idle();
    manual_ack = 1'b0;
    check("last_bit_checked", 64'(checked), 64'(2));
    check("last_bit_no_key", 64'(bus.KEY_VALID), 64'(0));
    check("last_bit_found_sticky", 64'(found), 64'(1));

    // Reset held three cycles while a candidate is running.
    bitstream = 48'h0;
    send(24'h0, 24'h0);
    repeat (5) @(negedge clk);
    check("mid_run_busy", 64'(busy), 64'(1));
    apply_reset();
    @(negedge clk);
    check("rst_run_key_valid", 64'(bus.KEY_VALID), 64'(0));
    check("rst_run_found", 64'(found), 64'(0));
    check("rst_run_checked", 64'(checked), 64'(0));
    check("rst_run_ready", 64'(bus.CAND_READY), 64'(1));

    // Stream: 1000 random candidates plus the known one, random gaps, random acks.
    bitstream   = stream4;
    auto_ack    = 1'b1;
    exp_hits    = 0;
    exp_rej     = 0;
    base_hits   = hits_seen;
    base_events = events_seen;
    ins = $urandom_range(0, 1000);
    for (int n = 0; n < 1001; n++) begin
      if (n == ins) begin
        re = 24'h0;
        ro = 24'hFFFFFF;
      end else begin
        re = 24'($urandom);
        ro = 24'($urandom);
      end
      x = make_exp(re, ro, bitstream);
      if (x.hit) exp_hits++;
      else       exp_rej++;
      send(re, ro);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    check("stream_keys", 64'(hits_seen - base_hits), 64'(exp_hits));
    check("stream_checked_model", 64'(checked), 64'(exp_rej));
    check("stream_checked_1000", 64'(checked), 64'(1000));
    check("stream_events", 64'(events_seen - base_events), 64'(1001));
    check("stream_queue_empty", 64'(exp_q.size()), 64'(0));

    // Random candidates against their own keystream, mostly with one bit flipped.
    for (int n = 0; n < 24; n++) begin
      wait_idle();
      re = 24'($urandom);
      ro = 24'($urandom);
      ks = model_keystream(re, ro);
      if (n % 4 == 3) bitstream = ks;
      else            bitstream = ks ^ (48'd1 << $urandom_range(0, 47));
      send(re, ro);
    end
    wait_idle();
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
